rv_fetch_unit: RTL

Parametrised instruction-fetch stage for the RV32I core family. It replaces the fixed PC / PC adder / instruction-memory chain with a pipelined fetch engine. The engine drives a synchronous 1-cycle-latency instruction memory, buffers returned words in a small FIFO, and hands instructions to decode over a valid/ready handshake. It also accepts redirects (branch/jump) with flush, and detects misaligned targets.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/rv_fetch_fifo.sv | 86 ++++++++
 rtl/rv_fetch_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RV32I fetch slice: default data/address width,
// default reset vector, the canonical NOP encoding (addi x0, x0, 0) and the
// fetch engine state encoding.
// ----------------------------------------------------------------------------
package rv_pkg;

  localparam int unsigned XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  // RUN fetches normally; HALT is entered on a misaligned redirect target and
  // is only left through reset.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/rv_fetch_fifo.sv
// ----------------------------------------------------------------------------
// rv_fetch_fifo
// Small synchronous FIFO buffering fetched {instruction, pc} entries between
// the instruction memory and decode. DEPTH must be a power of two so the
// pointers wrap naturally.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous reset, active-low
//   push_i   - write wdata_i at the tail (caller guarantees not full)
//   pop_i    - advance the head (ignored when empty)
//   flush_i  - discard every entry; overrides push_i and pop_i
//   wdata_i  - entry to write
//   rdata_o  - entry at the head (meaningful only when !empty_o)
//   count_o  - number of valid entries
//   empty_o  - no valid entries
// ----------------------------------------------------------------------------
module rv_fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  // Pointer and occupancy update; a flush returns the FIFO to its reset shape.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count is nonzero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/rv_fetch_unit.sv
// ----------------------------------------------------------------------------
// rv_fetch_unit
// Pipelined instruction-fetch stage. Issues word-aligned requests to a
// synchronous 1-cycle-latency instruction memory, buffers returned words with
// their PC in rv_fetch_fifo, and presents them to decode over valid/ready.
// Redirects flush the buffer and drop any in-flight return; a misaligned
// redirect target raises a sticky error and halts fetch until reset.
//
// Ports:
//   clk            - clock, rising edge
//   rst            - asynchronous reset, active-low
//   imem_req       - fetch request this cycle
//   imem_addr      - request byte address (zero when no request)
//   imem_rdata     - instruction word, valid one cycle after a request
//   redirect_valid - taken branch/jump, overrides everything
//   redirect_pc    - redirect target
//   instr_valid    - head of the instruction buffer is valid
//   instr_ready    - decode accepts the head
//   instr          - head instruction (holds last head when empty)
//   instr_pc       - PC of the head
//   instr_pcp4     - instr_pc + 4
//   fetch_err      - sticky misaligned-redirect error
// ----------------------------------------------------------------------------
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned      XLEN         = rv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(rv_pkg::RESET_VECTOR),
  parameter int unsigned      FIFO_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pcp4,
  output logic            fetch_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;
  localparam int unsigned EW = 32 + XLEN;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            inflight_q, inflight_d;
  logic            fetch_err_q, fetch_err_d;

  logic [31:0]     instr_hold_q;
  logic [XLEN-1:0] pc_hold_q, pcp4_hold_q;

  logic            running, redirect, misaligned;
  logic            issue, push, pop;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_rdata;
  logic [OW-1:0]   occupancy;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc, head_pcp4;

  assign running    = (state_q == RUN);
  assign redirect   = running && redirect_valid;
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  assign instr_valid = running && !fifo_empty;
  assign pop         = instr_valid && instr_ready;

  // A return belonging to a request issued before a redirect is stale; the
  // flush in the redirect cycle and the cleared in-flight flag both drop it.
  assign push = inflight_q && !redirect;

  // Slots already claimed after this cycle's pop: buffered words plus the one
  // returning now. Issuing only below FIFO_DEPTH makes overflow impossible.
  assign occupancy = OW'(fifo_count) - OW'(pop) + OW'(inflight_q);

  // Gating with rst keeps the request low while reset is held, since the
  // state registers alone would already allow an issue.
  assign issue = rst && running && !redirect && (occupancy < OW'(FIFO_DEPTH));

  assign imem_req  = issue;
  assign imem_addr = issue ? pc_q : '0;

  rv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({imem_rdata, req_addr_q}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Next-state for the fetch engine. A redirect overrides the sequential PC
  // and, when the target is not word-aligned, halts fetch with a sticky error.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    inflight_d  = issue;
    fetch_err_d = fetch_err_q;
    if (issue) begin
      pc_d       = pc_q + XLEN'(4);
      req_addr_d = pc_q;
    end
    if (redirect) begin
      pc_d = redirect_pc;
      if (misaligned) begin
        state_d     = HALT;
        fetch_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_VECTOR;
      req_addr_q  <= '0;
      inflight_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      inflight_q  <= inflight_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign head_instr = fifo_rdata[EW-1 -: 32];
  assign head_pc    = fifo_rdata[XLEN-1:0];
  assign head_pcp4  = head_pc + XLEN'(4);

  // Remember the last visible head so decode-side outputs stay stable while
  // the buffer is empty, and read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_hold_q <= '0;
      pc_hold_q    <= '0;
      pcp4_hold_q  <= '0;
    end else if (instr_valid) begin
      instr_hold_q <= head_instr;
      pc_hold_q    <= head_pc;
      pcp4_hold_q  <= head_pcp4;
    end
  end

  assign instr      = instr_valid ? head_instr : instr_hold_q;
  assign instr_pc   = instr_valid ? head_pc    : pc_hold_q;
  assign instr_pcp4 = instr_valid ? head_pcp4  : pcp4_hold_q;
  assign fetch_err  = fetch_err_q;

endmodule
